pll_reconfig_seq: RTL and testbench
===================================

Name: pll_reconfig_seq

Overview:
- Generic PLL dynamic-reconfiguration sequencer, in the CLK_50M domain next to pll_cfg.
- Generalises the inline model/ntsc reconfig logic to MODES selectable clock configurations held in parameter tables.
- Watches a mode select, debounces it, and replays a fixed 6-write register sequence over the Avalon-MM mgmt interface.
- Then waits for PLL lock with a timeout and reports busy, applied mode and lock error to the core reset logic.

Parameters:
- MODES, 4, number of clock configurations (2..16).
- MODE_W, 2, width of mode select; 2**MODE_W >= MODES.
- STABLE_CYCLES, 2, consecutive identical synchronised samples required to accept a new mode (1..255).
- LOCK_TIMEOUT, 5_000_000, CLK_50M cycles to wait for pll_locked after the start write.
- N_TABLE, 0, MODES*32 packed; mode i occupies bits [32*i +: 32]; N counter value.
- M_TABLE, 0, same packing; M counter value.
- C_TABLE, 0, same packing; C counter word including counter-select bits.
- K_TABLE, 0, same packing; fractional K value.

Ports:
- CLK_50M  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- mode_sel  in  MODE_W  requested mode, asynchronous to CLK_50M.
- force  in  1  one-cycle pulse: re-apply current mode even if unchanged.
- mgmt_waitrequest  in  1  from pll_cfg.
- mgmt_write  out  1  Avalon write strobe.
- mgmt_address  out  6  register address.
- mgmt_writedata  out  32  register data.
- pll_locked  in  1  PLL lock, asynchronous.
- busy  out  1  high from sequence start until lock or timeout.
- cur_mode  out  MODE_W  last mode whose sequence was started.
- lock_err  out  1  sticky: last sequence timed out.

Behaviour:
- Reset values:
  - mgmt_write=0, mgmt_address=0, mgmt_writedata=0, busy=0, cur_mode=0, lock_err=0.
  - Internal dirty flag=1, so one full sequence runs once the select is stable after reset.
- Reset taken mid-operation: the sequence aborts immediately, mgmt_write drops in the same cycle, and the module restarts as above.
- Input sync: mode_sel and pll_locked each pass through 2 flops before use.
- Debounce:
  - Counter reloads when the synchronised mode_sel differs from the previous sample.
  - The sample is accepted after STABLE_CYCLES equal samples.
  - An accepted value that differs from cur_mode, or the dirty flag, or a force pulse, sets the pending flag.
  - mode_sel >= MODES is never accepted; the prior value is kept.
- FSM states: IDLE, WR, GAP, LOCK_WAIT.
  - IDLE with pending: latch the mode into cur_mode, clear pending and dirty, set busy, idx=0, go to WR.
  - WR: drive mgmt_write=1 with address/data for idx. Hold all three stable while mgmt_waitrequest=1. On the first cycle with mgmt_waitrequest=0, the write is accepted: deassert next cycle and go to GAP.
  - GAP: one idle cycle, then idx+1 goes to WR. After idx=5 go to LOCK_WAIT with the timeout counter cleared.
  - Write order (idx: addr, data):
    - 0: 0, 0 (waitrequest mode)
    - 1: 3, N
    - 2: 4, M
    - 3: 5, C
    - 4: 7, K
    - 5: 2, 0 (start)
  - LOCK_WAIT: ignore pll_locked for the first 16 cycles, since lock drops only after start.
    - Then synced pll_locked=1 clears busy and lock_err, and the FSM returns to IDLE.
    - If the counter reaches LOCK_TIMEOUT-1 first, set lock_err, clear busy, return to IDLE. No automatic retry.
- Minimum sequence length with waitrequest tied 0 is 12 cycles of writes: 6×(WR+GAP).
- Mode change or force during WR, GAP or LOCK_WAIT: never aborts the sequence. It only sets pending; the new sequence starts from IDLE after the current one completes. Multiple changes collapse to the latest accepted mode.
- force coinciding with a debounced mode change: a single pending sequence.
- mgmt_write is never asserted outside WR.

Test Plan:
- Reset, mode_sel=1, waitrequest=0, tables N=0x10000+i, M=0x20000+i, C=0x30000+i, K=0x40000+i:
  - writes (0,0),(3,0x10001),(4,0x20001),(5,0x30001),(7,0x40001),(2,0) in order, mgmt_write high exactly 1 cycle each, 1-cycle gaps.
  - busy high until 16+ cycles later, when locked asserted → busy=0, cur_mode=1.
- waitrequest held high 5 cycles during idx=2:
  - mgmt_write, address=4 and data stay stable for all 6 cycles; exactly one accepted write; next write follows after 1 gap cycle.
- mode_sel glitches 1→2→1 for 1 cycle each with STABLE_CYCLES=2 and cur_mode=1 → no sequence.
- mode_sel 1→3 held → exactly one sequence with cur_mode=3.
- mode_sel changed to 2 during idx=3 of a mode-0 sequence:
  - the mode-0 sequence completes unaltered, lock is reached, then a mode-2 sequence starts.
- pll_locked held 0, LOCK_TIMEOUT=1000:
  - lock_err=1 and busy=0 at cycle 1000 of LOCK_WAIT.
  - A subsequent force with lock returned clears lock_err.
- RESET asserted during idx=4 write with waitrequest=1:
  - mgmt_write=0 the next cycle, all outputs at reset values.
  - After release, a full sequence restarts from idx=0.

Source files
------------

// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: debounced mode select replays a 6-write PLL reconfig over Avalon-MM then waits for lock; ports: CLK_50M/RESET, mode_sel/force_req in, mgmt_* master, pll_locked in, busy/cur_mode/lock_err out
module pll_reconfig_seq #(
  parameter int MODES = 4,
  parameter int MODE_W = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int LOCK_TIMEOUT = 5_000_000,
  parameter logic [MODES*32-1:0] N_TABLE = '0,
  parameter logic [MODES*32-1:0] M_TABLE = '0,
  parameter logic [MODES*32-1:0] C_TABLE = '0,
  parameter logic [MODES*32-1:0] K_TABLE = '0
) (
  input  logic              CLK_50M,
  input  logic              RESET,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              force_req,
  input  logic              mgmt_waitrequest,
  output logic              mgmt_write,
  output logic [5:0]        mgmt_address,
  output logic [31:0]       mgmt_writedata,
  input  logic              pll_locked,
  output logic              busy,
  output logic [MODE_W-1:0] cur_mode,
  output logic              lock_err
);
  typedef enum logic [1:0] {IDLE, WR, GAP, LOCK_WAIT} state_t;
  state_t state;
  logic [MODE_W-1:0] mode_s1, mode_s2, mode_prev, acc_mode;
  logic lock_s1, lock_s2;
  logic [1:0] sync_vld;
  logic [7:0] stable_cnt;
  logic have_acc, dirty, force_flag, accept, pending, start;
  logic [2:0] idx;
  logic [31:0] tcnt;

  function automatic logic [5:0] addr_of(input logic [2:0] i);
    return i == 3'd0 ? 6'd0 : i == 3'd1 ? 6'd3 : i == 3'd2 ? 6'd4 :
           i == 3'd3 ? 6'd5 : i == 3'd4 ? 6'd7 : 6'd2;
  endfunction

  function automatic logic [31:0] data_of(input logic [2:0] i, input logic [MODE_W-1:0] m);
    return i == 3'd1 ? N_TABLE[32*m +: 32] : i == 3'd2 ? M_TABLE[32*m +: 32] :
           i == 3'd3 ? C_TABLE[32*m +: 32] : i == 3'd4 ? K_TABLE[32*m +: 32] : 32'd0;
  endfunction

  assign accept = stable_cnt >= 8'(STABLE_CYCLES) && 32'(mode_prev) < MODES;
  assign pending = force_flag || (have_acc && (dirty || acc_mode != cur_mode));
  assign start = state == IDLE && pending;

  always_ff @(posedge CLK_50M)
    if (RESET) begin
      mode_s1 <= '0;
      mode_s2 <= '0;
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      sync_vld <= 2'b00;
      mode_prev <= '0;
      stable_cnt <= 8'd0;
      acc_mode <= '0;
      have_acc <= 1'b0;
    end else begin
      mode_s1 <= mode_sel;
      mode_s2 <= mode_s1;
      lock_s1 <= pll_locked;
      lock_s2 <= lock_s1;
      sync_vld <= {sync_vld[0], 1'b1};
      mode_prev <= mode_s2;
      stable_cnt <= !sync_vld[1] ? 8'd0 :
                    stable_cnt == 8'd0 || mode_s2 != mode_prev ? 8'd1 :
                    stable_cnt >= 8'(STABLE_CYCLES) ? stable_cnt : stable_cnt + 8'd1;
      if (accept) begin
        acc_mode <= mode_prev;
        have_acc <= 1'b1;
      end
    end

  always_ff @(posedge CLK_50M)
    if (RESET) begin
      state <= IDLE;
      mgmt_write <= 1'b0;
      mgmt_address <= 6'd0;
      mgmt_writedata <= 32'd0;
      busy <= 1'b0;
      cur_mode <= '0;
      lock_err <= 1'b0;
      dirty <= 1'b1;
      force_flag <= 1'b0;
      idx <= 3'd0;
      tcnt <= 32'd0;
    end else begin
      force_flag <= start ? force_req : force_flag | force_req;
      case (state)
        IDLE:
          if (pending) begin
            state <= WR;
            cur_mode <= acc_mode;
            dirty <= 1'b0;
            busy <= 1'b1;
            idx <= 3'd0;
            mgmt_write <= 1'b1;
            mgmt_address <= addr_of(3'd0);
            mgmt_writedata <= data_of(3'd0, acc_mode);
          end
        WR:
          if (!mgmt_waitrequest) begin
            mgmt_write <= 1'b0;
            state <= GAP;
          end
        GAP:
          if (idx == 3'd5) begin
            state <= LOCK_WAIT;
            tcnt <= 32'd0;
          end else begin
            idx <= idx + 3'd1;
            state <= WR;
            mgmt_write <= 1'b1;
            mgmt_address <= addr_of(idx + 3'd1);
            mgmt_writedata <= data_of(idx + 3'd1, cur_mode);
          end
        LOCK_WAIT:
          if (tcnt >= 32'd16 && lock_s2) begin
            busy <= 1'b0;
            lock_err <= 1'b0;
            state <= IDLE;
          end else if (tcnt == 32'(LOCK_TIMEOUT - 1)) begin
            busy <= 1'b0;
            lock_err <= 1'b1;
            state <= IDLE;
          end else
            tcnt <= tcnt + 32'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: randomized self-checking bench for pll_reconfig_seq against a write-list/lock-timing model
module tb_pll_reconfig_seq;
  localparam int MODES = 4;
  localparam int MODE_W = 2;
  localparam int STABLE = 2;
  localparam int TMO = 1000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [MODE_W-1:0] mode_sel = 2'd1;
  logic force_req = 1'b0;
  logic waitreq = 1'b0;
  logic pll_locked = 1'b0;
  logic mgmt_write;
  logic [5:0] mgmt_address;
  logic [31:0] mgmt_writedata;
  logic busy;
  logic [MODE_W-1:0] cur_mode;
  logic lock_err;
  int checks = 0;
  int errors = 0;
  logic [5:0] got_a[$];
  logic [31:0] got_d[$];
  int proto_bad, done_c, stall_seen, cur_m;

  always #10 clk = ~clk;

  pll_reconfig_seq #(
    .MODES(MODES), .MODE_W(MODE_W), .STABLE_CYCLES(STABLE), .LOCK_TIMEOUT(TMO),
    .N_TABLE({32'h0001_0003, 32'h0001_0002, 32'h0001_0001, 32'h0001_0000}),
    .M_TABLE({32'h0002_0003, 32'h0002_0002, 32'h0002_0001, 32'h0002_0000}),
    .C_TABLE({32'h0003_0003, 32'h0003_0002, 32'h0003_0001, 32'h0003_0000}),
    .K_TABLE({32'h0004_0003, 32'h0004_0002, 32'h0004_0001, 32'h0004_0000})
  ) dut (
    .CLK_50M(clk), .RESET(rst), .mode_sel(mode_sel), .force_req(force_req),
    .mgmt_waitrequest(waitreq), .mgmt_write(mgmt_write), .mgmt_address(mgmt_address),
    .mgmt_writedata(mgmt_writedata), .pll_locked(pll_locked), .busy(busy),
    .cur_mode(cur_mode), .lock_err(lock_err)
  );

  function automatic logic [5:0] exp_addr(input int i);
    int a[6];
    a = '{0, 3, 4, 5, 7, 2};
    return 6'(a[i]);
  endfunction

  function automatic logic [31:0] exp_data(input int m, input int i);
    return (i == 0 || i == 5) ? 32'd0 : 32'((i << 16) + m);
  endfunction

  function automatic int n_bad(input int m);
    int b = 0;
    if (got_a.size() != 6) return 6;
    for (int i = 0; i < 6; i++)
      if (got_a[i] !== exp_addr(i) || got_d[i] !== exp_data(m, i)) b++;
    return b;
  endfunction

  function automatic int exp_done(input int lock_at);
    return lock_at < 0 ? TMO + 2 : (lock_at > 16 ? lock_at : 16) + 3;
  endfunction

  task automatic pulse_force();
    @(negedge clk);
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
  endtask

  task automatic run_seq(input int stall_pct, input int stall_idx, input int stall_len,
                         input int chg_idx, input int chg_mode, input int lock_at);
    int acc6 = -1;
    int last_acc = -10;
    int stall_left = 0;
    bit prev_stall = 0;
    bit just_acc = 0;
    logic [5:0] pa = 6'd0;
    logic [31:0] pd = 32'd0;
    got_a.delete();
    got_d.delete();
    proto_bad = 0;
    done_c = -1;
    stall_seen = 0;
    for (int i = 0; i < 200 && !busy; i++) @(negedge clk);
    if (!busy) return;
    pll_locked = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (acc6 >= 0 && !busy) begin
        done_c = cyc - acc6;
        break;
      end
      if (prev_stall && (!mgmt_write || mgmt_address !== pa || mgmt_writedata !== pd)) proto_bad++;
      if (just_acc && mgmt_write) proto_bad++;
      if (acc6 >= 0 && mgmt_write) proto_bad++;
      if (mgmt_write && !prev_stall && got_a.size() > 0 && cyc != last_acc + 2) proto_bad++;
      if (mgmt_write && !prev_stall && got_a.size() == stall_idx) stall_left = stall_len;
      if (mgmt_write && !prev_stall && got_a.size() == chg_idx) mode_sel = 2'(chg_mode);
      just_acc = 0;
      prev_stall = 0;
      if (mgmt_write && acc6 < 0) begin
        if (stall_left > 0 || $urandom_range(99) < stall_pct) begin
          waitreq = 1'b1;
          prev_stall = 1;
          pa = mgmt_address;
          pd = mgmt_writedata;
          stall_seen++;
          if (stall_left > 0) stall_left--;
        end else begin
          waitreq = 1'b0;
          got_a.push_back(mgmt_address);
          got_d.push_back(mgmt_writedata);
          just_acc = 1;
          last_acc = cyc;
          if (got_a.size() == 6) acc6 = cyc;
        end
      end else
        waitreq = 1'($urandom_range(1));
      if (acc6 >= 0 && lock_at >= 0 && cyc - acc6 == lock_at) pll_locked = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mode_sel = 2'd1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mgmt_write, busy, lock_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got write/busy/err=%b want 000", {mgmt_write, busy, lock_err});
    end
    checks++;
    if (cur_mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_cur_mode got %0d want 0", cur_mode);
    end
    checks++;
    if (mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
      errors++;
      $display("FAIL reset_bus got addr=%0d data=%h want 0/0", mgmt_address, mgmt_writedata);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_seq();
    run_seq(0, -1, 0, -1, 0, 5);
    cur_m = 1;
    checks++;
    if (n_bad(1) != 0) begin
      errors++;
      $display("FAIL first_writes got %0d bad of %0d writes want 0 bad", n_bad(1), got_a.size());
    end
    checks++;
    if (proto_bad != 0) begin
      errors++;
      $display("FAIL first_protocol got %0d violations want 0", proto_bad);
    end
    checks++;
    if (done_c != exp_done(5)) begin
      errors++;
      $display("FAIL first_busy_len got %0d want %0d", done_c, exp_done(5));
    end
    checks++;
    if (cur_mode !== 2'd1 || lock_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL first_status got mode=%0d err=%b busy=%b want 1/0/0", cur_mode, lock_err, busy);
    end
  endtask

  task automatic test_stall();
    pulse_force();
    run_seq(0, 2, 5, -1, 0, 30);
    checks++;
    if (n_bad(1) != 0 || proto_bad != 0) begin
      errors++;
      $display("FAIL stall_writes got bad=%0d proto=%0d want 0/0", n_bad(1), proto_bad);
    end
    checks++;
    if (stall_seen != 5) begin
      errors++;
      $display("FAIL stall_cycles got %0d want 5", stall_seen);
    end
    checks++;
    if (done_c != exp_done(30)) begin
      errors++;
      $display("FAIL stall_busy_len got %0d want %0d", done_c, exp_done(30));
    end
  endtask

  task automatic test_glitch();
    bit rose = 0;
    @(negedge clk);
    mode_sel = 2'd2;
    @(negedge clk);
    mode_sel = 2'd1;
    repeat (40) begin
      @(negedge clk);
      if (busy) rose = 1;
    end
    checks++;
    if (rose || cur_mode !== 2'd1) begin
      errors++;
      $display("FAIL glitch got busy_rose=%0d mode=%0d want 0/1", rose, cur_mode);
    end
  endtask

  task automatic test_change();
    int la = int'($urandom_range(10, 40));
    bit rose = 0;
    mode_sel = 2'd3;
    run_seq(20, -1, 0, -1, 0, la);
    cur_m = 3;
    checks++;
    if (n_bad(3) != 0 || proto_bad != 0) begin
      errors++;
      $display("FAIL change_writes got bad=%0d proto=%0d want 0/0", n_bad(3), proto_bad);
    end
    checks++;
    if (done_c != exp_done(la) || cur_mode !== 2'd3) begin
      errors++;
      $display("FAIL change_status got len=%0d mode=%0d want %0d/3", done_c, cur_mode, exp_done(la));
    end
    repeat (40) begin
      @(negedge clk);
      if (busy) rose = 1;
    end
    checks++;
    if (rose) begin
      errors++;
      $display("FAIL change_once got extra sequence=1 want 0");
    end
  endtask

  task automatic test_midseq();
    mode_sel = 2'd0;
    run_seq(0, -1, 0, 3, 2, 20);
    checks++;
    if (n_bad(0) != 0 || proto_bad != 0 || cur_mode !== 2'd0) begin
      errors++;
      $display("FAIL midseq_first got bad=%0d proto=%0d mode=%0d want 0/0/0", n_bad(0), proto_bad, cur_mode);
    end
    run_seq(0, -1, 0, -1, 0, 20);
    cur_m = 2;
    checks++;
    if (n_bad(2) != 0 || proto_bad != 0 || cur_mode !== 2'd2) begin
      errors++;
      $display("FAIL midseq_second got bad=%0d proto=%0d mode=%0d want 0/0/2", n_bad(2), proto_bad, cur_mode);
    end
  endtask

  task automatic test_timeout();
    pulse_force();
    run_seq(0, -1, 0, -1, 0, -1);
    checks++;
    if (done_c != TMO + 2) begin
      errors++;
      $display("FAIL timeout_len got %0d want %0d", done_c, TMO + 2);
    end
    checks++;
    if (lock_err !== 1'b1 || busy !== 1'b0 || n_bad(2) != 0) begin
      errors++;
      $display("FAIL timeout_status got err=%b busy=%b bad=%0d want 1/0/0", lock_err, busy, n_bad(2));
    end
    pll_locked = 1'b1;
    pulse_force();
    run_seq(0, -1, 0, -1, 0, 25);
    checks++;
    if (lock_err !== 1'b0 || done_c != exp_done(25)) begin
      errors++;
      $display("FAIL timeout_clear got err=%b len=%0d want 0/%0d", lock_err, done_c, exp_done(25));
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    int m;
    waitreq = 1'b0;
    pulse_force();
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mgmt_write && mgmt_address == 6'd7) seen = 1;
    end
    waitreq = 1'b1;
    @(negedge clk);
    checks++;
    if (!seen || mgmt_write !== 1'b1 || mgmt_address !== 6'd7) begin
      errors++;
      $display("FAIL rstmid_stall got seen=%0d write=%b addr=%0d want 1/1/7", seen, mgmt_write, mgmt_address);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mgmt_write, busy, lock_err} !== 3'b000 || cur_mode !== 2'd0 || mgmt_address !== 6'd0 || mgmt_writedata !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got write/busy/err=%b mode=%0d addr=%0d data=%h want 000/0/0/0",
               {mgmt_write, busy, lock_err}, cur_mode, mgmt_address, mgmt_writedata);
    end
    m = int'($urandom_range(3));
    mode_sel = 2'(m);
    @(negedge clk);
    rst = 1'b0;
    waitreq = 1'b0;
    run_seq(30, -1, 0, -1, 0, 18);
    cur_m = m;
    checks++;
    if (n_bad(m) != 0 || proto_bad != 0 || cur_mode !== 2'(m)) begin
      errors++;
      $display("FAIL rstmid_restart got bad=%0d proto=%0d mode=%0d want 0/0/%0d", n_bad(m), proto_bad, cur_mode, m);
    end
  endtask

  task automatic test_random();
    int m, la;
    for (int k = 0; k < 4; k++) begin
      m = (cur_m + int'($urandom_range(1, 3))) % MODES;
      la = int'($urandom_range(0, 40));
      mode_sel = 2'(m);
      run_seq(40, -1, 0, -1, 0, la);
      cur_m = m;
      checks++;
      if (n_bad(m) != 0 || proto_bad != 0) begin
        errors++;
        $display("FAIL random%0d_writes got bad=%0d proto=%0d want 0/0", k, n_bad(m), proto_bad);
      end
      checks++;
      if (done_c != exp_done(la) || cur_mode !== 2'(m) || lock_err !== 1'b0) begin
        errors++;
        $display("FAIL random%0d_status got len=%0d mode=%0d err=%b want %0d/%0d/0",
                 k, done_c, cur_mode, lock_err, exp_done(la), m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_seq();
    test_stall();
    test_glitch();
    test_change();
    test_midseq();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
